// File: rtl/pixel_readout_pkg.sv
// Shared types, default sizes and Gray-code helpers for the pixel readout controller.
// The PIXEL_GRAY_EN build option is consumed by the modules that import this package.
package pixel_readout_pkg;

    localparam int unsigned DefaultN           = 8;
    localparam int unsigned DefaultNumPixels   = 4;
    localparam int unsigned DefaultEraseCycles = 5;
    localparam int unsigned ExpW               = 16;

    typedef enum logic [2:0] {
        StIdle,
        StErase,
        StExpose,
        StConvert,
        StTurn,
        StRdSel,
        StRdOut,
        StDone
    } state_e;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/pixel_ramp_counter.sv
// N-bit ramp counter with clear/enable, saturating at its terminal count.
// Under PIXEL_GRAY_EN the registered bus code is the Gray form of the count.
module pixel_ramp_counter
    import pixel_readout_pkg::*;
#(
    parameter int unsigned N = DefaultN
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [N-1:0] code_o,
    output logic         tc_o
);

    logic [N-1:0] bin_q, bin_d;
    logic [N-1:0] code_q, code_d;

    assign tc_o   = (bin_q == '1);
    assign code_o = code_q;

    // Clear wins over enable; the count never wraps on its own.
    always_comb begin
        bin_d = bin_q;
        if (clr_i) begin
            bin_d = '0;
        end else if (en_i && !tc_o) begin
            bin_d = bin_q + N'(1);
        end
    end

`ifdef PIXEL_GRAY_EN
    assign code_d = N'(bin2gray(32'(bin_d)));
`else
    assign code_d = bin_d;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bin_q  <= '0;
            code_q <= '0;
        end else begin
            bin_q  <= bin_d;
            code_q <= code_d;
        end
    end

endmodule

// File: rtl/pixel_readout_ctrl.sv
// Frame sequencer and bus master: erase, expose, ramp convert, then per-pixel readout.
// Build option PIXEL_GRAY_EN puts Gray codes on the bus and decodes them on capture.
module pixel_readout_ctrl
    import pixel_readout_pkg::*;
#(
    parameter int unsigned N            = DefaultN,
    parameter int unsigned NUM_PIXELS   = DefaultNumPixels,
    parameter int unsigned ERASE_CYCLES = DefaultEraseCycles,
    parameter int unsigned IDX_W        = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ExpW-1:0]       exp_time,
    output logic                  erase,
    output logic                  expose,
    output logic                  convert,
    output logic [NUM_PIXELS-1:0] read,
    output logic [N-1:0]          bus_o,
    output logic                  bus_oe,
    input  logic [N-1:0]          bus_i,
    output logic [N-1:0]          pix_data,
    output logic [IDX_W-1:0]      pix_idx,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  busy,
    output logic                  frame_done
);

    localparam logic [ExpW-1:0]  EraseLast = ExpW'(ERASE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IdxLast   = IDX_W'(NUM_PIXELS - 1);

    state_e                state_q, state_d;
    logic [ExpW-1:0]       cnt_q, cnt_d;
    logic [ExpW-1:0]       exp_q, exp_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [N-1:0]          data_q, data_d;
    logic [N-1:0]          capture;
    logic [NUM_PIXELS-1:0] read_q, read_d;
    logic                  erase_q, expose_q, convert_q, bus_oe_q;
    logic                  valid_q, busy_q, done_q;
    logic                  ramp_tc;
    logic                  xfer;

`ifdef PIXEL_GRAY_EN
    assign capture = N'(gray2bin(32'(bus_i)));
`else
    assign capture = bus_i;
`endif

    assign xfer = valid_q & pix_ready;

    // Counter is held at zero outside CONVERT so the first convert cycle drives code 0.
    pixel_ramp_counter #(
        .N (N)
    ) u_ramp (
        .clk_i  (clk),
        .rst_i  (rst),
        .clr_i  (state_d != StConvert),
        .en_i   (state_q == StConvert),
        .code_o (bus_o),
        .tc_o   (ramp_tc)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        idx_d   = idx_q;
        data_d  = data_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StErase;
                    cnt_d   = '0;
                    idx_d   = '0;
                    exp_d   = (exp_time == '0) ? ExpW'(1) : exp_time;
                end
            end
            StErase: begin
                if (cnt_q == EraseLast) begin
                    state_d = StExpose;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ExpW'(1);
                end
            end
            StExpose: begin
                if (cnt_q == exp_q - ExpW'(1)) begin
                    state_d = StConvert;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ExpW'(1);
                end
            end
            StConvert: begin
                if (ramp_tc) begin
                    state_d = StTurn;
                end
            end
            StTurn: begin
                state_d = StRdSel;
                cnt_d   = '0;
            end
            StRdSel: begin
                // Select is held two cycles; the bus settles before the capture edge.
                if (cnt_q[0]) begin
                    state_d = StRdOut;
                    data_d  = capture;
                end else begin
                    cnt_d = cnt_q + ExpW'(1);
                end
            end
            StRdOut: begin
                if (xfer) begin
                    if (idx_q == IdxLast) begin
                        state_d = StDone;
                    end else begin
                        state_d = StRdSel;
                        idx_d   = idx_q + IDX_W'(1);
                        cnt_d   = '0;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        read_d = '0;
        for (int i = 0; i < int'(NUM_PIXELS); i++) begin
            read_d[i] = (state_d == StRdSel) && (idx_d == IDX_W'(i));
        end
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            exp_q     <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            read_q    <= '0;
            erase_q   <= 1'b0;
            expose_q  <= 1'b0;
            convert_q <= 1'b0;
            bus_oe_q  <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            exp_q     <= exp_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            read_q    <= read_d;
            erase_q   <= (state_d == StErase);
            expose_q  <= (state_d == StExpose);
            convert_q <= (state_d == StConvert);
            bus_oe_q  <= (state_d == StConvert);
            valid_q   <= (state_d == StRdOut);
            busy_q    <= (state_d != StIdle);
            done_q    <= (state_d == StDone);
        end
    end

    assign erase      = erase_q;
    assign expose     = expose_q;
    assign convert    = convert_q;
    assign bus_oe     = bus_oe_q;
    assign read       = read_q;
    assign pix_data   = data_q;
    assign pix_idx    = idx_q;
    assign pix_valid  = valid_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// Self-checking bench for pixel_readout_ctrl: a timeline model of each frame plus a
// pixel-array model that latches the ramp code when it reaches each pixel's level.
module tb_pixel_readout_ctrl;

    localparam int N  = 8;
    localparam int NP = 4;
    localparam int EC = 5;
    localparam int IW = 2;
    localparam int C  = 1 << N;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [15:0]   exp_time = '0;
    logic          erase, expose, convert, bus_oe, pix_valid, busy, frame_done;
    logic [NP-1:0] read;
    logic [N-1:0]  bus_o, bus_i, pix_data;
    logic [IW-1:0] pix_idx;
    logic          pix_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [N-1:0] lvl [NP];
    logic [N-1:0] lat [NP];
    logic [N-1:0] obs_bus3;
    logic [N-1:0] obs_pix3;
    int           done_seen;

    always #5 clk = ~clk;

    pixel_readout_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .exp_time   (exp_time),
        .erase      (erase),
        .expose     (expose),
        .convert    (convert),
        .read       (read),
        .bus_o      (bus_o),
        .bus_oe     (bus_oe),
        .bus_i      (bus_i),
        .pix_data   (pix_data),
        .pix_idx    (pix_idx),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // Shared bus: the controller while it drives, otherwise whichever pixel is selected.
    always_comb begin
        bus_i = '0;
        if (bus_oe) bus_i = bus_o;
        for (int i = 0; i < NP; i++) begin
            if (read[i]) bus_i = bus_i | lat[i];
        end
    end

    task automatic check(input string tag, input int k, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    function automatic logic [31:0] ramp_code(input int j);
`ifdef PIXEL_GRAY_EN
        return 32'(j ^ (j >> 1));
`else
        return 32'(j);
`endif
    endfunction

    task automatic check_zero(input string tag);
        check({tag, "_status"}, 0, 32'({busy, erase, expose, convert, bus_oe, frame_done}), 0);
        check({tag, "_read"}, 0, 32'(read), 0);
        check({tag, "_bus_o"}, 0, 32'(bus_o), 0);
        check({tag, "_valid"}, 0, 32'(pix_valid), 0);
        check({tag, "_data"}, 0, 32'(pix_data), 0);
        check({tag, "_idx"}, 0, 32'(pix_idx), 0);
    endtask

    task automatic rand_levels();
        for (int i = 0; i < NP; i++) lvl[i] = N'($urandom_range(0, C - 1));
    endtask

    // One frame. hold1: cycles pixel 1 is kept waiting; rst_j: convert index at which
    // rst is asserted (-1 = none); pulses: stray start pulses in EXPOSE and DONE.
    task automatic run_frame(input int t, input int rdy_pct, input int hold1,
                             input int rst_j, input bit pulses);
        int T, k, p, ss, done_k, stall, xfers, n_exp, n_done, j;
        bit rdy, exp_valid, conv, busy_e;
        logic [NP-1:0] exp_rd;
        T      = (t == 0) ? 1 : t;
        p      = 0;
        ss     = EC + T + C + 2;
        done_k = -1;
        stall  = 0;
        xfers  = 0;
        n_exp  = 0;
        n_done = 0;
        done_seen = -1;
        for (int i = 0; i < NP; i++) lat[i] = '0;
        @(negedge clk);
        start    = 1'b1;
        exp_time = 16'(t);
        @(negedge clk);
        start    = 1'b0;
        exp_time = 16'($urandom);
        k = 1;
        while (k < 6000) begin
            exp_rd    = '0;
            exp_valid = 1'b0;
            if (k >= EC + T + C + 2 && p < NP) begin
                if (k < ss + 2) exp_rd[p] = 1'b1;
                else exp_valid = 1'b1;
            end
            conv   = (k > EC + T) && (k <= EC + T + C);
            busy_e = (done_k < 0) || (k <= done_k);
            check("status", k, 32'({busy, erase, expose, convert, bus_oe, frame_done}),
                  32'({busy_e, k <= EC, (k > EC) && (k <= EC + T), conv, conv, k == done_k}));
            check("read", k, 32'(read), 32'(exp_rd));
            check("valid", k, 32'(pix_valid), 32'(exp_valid));
            check("contention", k, 32'(bus_oe & (|read)), 0);
            if (expose) n_exp++;
            if (frame_done) begin
                n_done++;
                done_seen = k;
            end
            if (conv) begin
                j = k - EC - T - 1;
                check("bus_o", k, 32'(bus_o), ramp_code(j));
                if (j == 3) obs_bus3 = bus_o;
                for (int i = 0; i < NP; i++) if (int'(lvl[i]) == j) lat[i] = bus_o;
                if (j == rst_j) begin
                    rst = 1'b1;
                    @(negedge clk);
                    check_zero("midrst");
                    rst = 1'b0;
                    return;
                end
            end
            if (exp_valid) begin
                check("pix_idx", k, 32'(pix_idx), 32'(p));
                check("pix_data", k, 32'(pix_data), 32'(lvl[p]));
            end
            if (exp_valid && p == 1 && stall < hold1) begin
                rdy = 1'b0;
                stall++;
            end else begin
                rdy = ($urandom_range(0, 99) < rdy_pct);
            end
            pix_ready = rdy;
            if (pulses) start = (k == EC + 2) || (k == done_k);
            if (exp_valid && rdy) begin
                if (p == NP - 1) obs_pix3 = pix_data;
                xfers++;
                p++;
                ss = k + 1;
                if (p == NP) done_k = k + 1;
            end
            if (done_k > 0 && k == done_k + 4) break;
            @(negedge clk);
            k++;
        end
        start     = 1'b0;
        pix_ready = 1'b0;
        check("xfers", k, 32'(xfers), NP);
        check("done_cycle", k, 32'(done_seen), 32'(done_k));
        check("done_count", k, 32'(n_done), 1);
        check("expose_len", k, 32'(n_exp), 32'(T));
    endtask

    initial begin
        for (int i = 0; i < NP; i++) begin
            lvl[i] = '0;
            lat[i] = '0;
        end
        obs_bus3 = '0;
        obs_pix3 = '0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        // Nominal frame with ready tied high.
        lvl[0] = 8'h12;
        lvl[1] = 8'h34;
        lvl[2] = 8'h56;
        lvl[3] = 8'h78;
        pix_ready = 1'b1;
        run_frame(10, 100, 0, -1, 1'b0);
        check("nominal_done", 0, 32'(done_seen), 285);
`ifdef PIXEL_GRAY_EN
        check("conv_idx3", 0, 32'(obs_bus3), 32'h02);
`else
        check("conv_idx3", 0, 32'(obs_bus3), 32'h03);
`endif

        // Backpressure on pixel 1, then zero exposure with random ready.
        lvl[0] = 8'h12;
        lvl[1] = 8'h34;
        lvl[2] = 8'h56;
        lvl[3] = 8'h78;
        run_frame(int'($urandom_range(1, 20)), 100, 7, -1, 1'b0);
        rand_levels();
        run_frame(0, 60, 0, -1, 1'b0);

        // Reset mid-convert, then a complete frame.
        rand_levels();
        run_frame(12, 100, 0, 'h40, 1'b0);
        rand_levels();
        run_frame(int'($urandom_range(1, 30)), 70, 0, -1, 1'b0);

        // Stray start pulses must not queue another frame.
        rand_levels();
        run_frame(8, 100, 0, -1, 1'b1);

        // Pixel at level 8 latches Gray 0x0C in the Gray build and still reads back 8.
        rand_levels();
        lvl[3] = 8'h08;
        run_frame(3, 80, 0, -1, 1'b0);
`ifdef PIXEL_GRAY_EN
        check("lat3", 0, 32'(lat[3]), 32'h0C);
`else
        check("lat3", 0, 32'(lat[3]), 32'h08);
`endif
        check("pix3", 0, 32'(obs_pix3), 32'h08);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_readout_ctrl.md
# pixel_readout_ctrl

Frame sequencer and bus master for the pixel array. It drives ERASE, EXPOSE and ramp-convert phases. During convert it drives the ADC code counter onto the shared data bus. It then reads every pixel's latched code back over the same bus and streams each code out with a valid/ready handshake. It sits between the pixel array and the downstream frame buffer.

## Interface
- N, 8, data bus / pixel code width
- NUM_PIXELS, 4, pixels on the bus (one read select each)
- ERASE_CYCLES, 5, erase pulse length in clocks
- IDX_W, $clog2(NUM_PIXELS), pixel index width (derived)

- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin one frame; sampled only in IDLE
- exp_time  in  16  exposure length in clocks; sampled with start
- erase  out  1  pixel erase
- expose  out  1  pixel exposure enable
- convert  out  1  ramp/convert enable
- read  out  NUM_PIXELS  one-hot pixel read select
- bus_o  out  N  value driven onto data bus
- bus_oe  out  1  bus output enable (tristate at top level)
- bus_i  in  N  data bus sampled value
- pix_data  out  N  captured pixel code
- pix_idx  out  IDX_W  index of pix_data
- pix_valid  out  1  pix_data valid
- pix_ready  in  1  downstream accepts
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse at frame end

## Operation
- All outputs are registered. Reset value of every output is 0; state is IDLE.
- States: IDLE, ERASE, EXPOSE, CONVERT, TURN, RD_SEL, RD_OUT, DONE.
- IDLE: start=1 latches exp_time and enters ERASE.
- ERASE: erase=1 for ERASE_CYCLES cycles, then EXPOSE.
- EXPOSE: expose=1 for exp_time cycles; exp_time=0 is treated as 1. Then CONVERT.
- CONVERT: convert=1, bus_oe=1. bus_o steps 0,1,…,2^N−1, one per cycle (2^N cycles, no wrap). Then TURN.
- TURN: one cycle with bus_oe=0 and read=0. This is the bus turnaround; contention is forbidden.
- RD_SEL: read[i]=1 for 2 cycles. bus_i is captured into pix_data at the end of the 2nd cycle. Then RD_OUT with read=0.
- RD_OUT: pix_valid=1, pix_idx=i. pix_data and pix_idx stay stable until pix_valid & pix_ready is sampled. On transfer, go to RD_SEL for i+1, or to DONE after i=NUM_PIXELS−1.
- DONE: frame_done=1 for one cycle, then IDLE.
- busy=1 in every state except IDLE.
- start in any non-IDLE state is ignored; it is not queued.
- rst mid-frame: next edge returns to IDLE with all outputs 0, bus_oe=0 and the transfer dropped.
- pix_ready while pix_valid=0 has no effect.

## Timing
- start sampled at edge 0.
- erase high in cycles 1..ERASE_CYCLES.
- expose high for the next exp_time cycles.
- convert/bus_oe high for the next 2^N cycles.
- TURN takes 1 cycle.
- Each pixel takes 2 (select) + ≥1 (valid) cycles.
- With pix_ready tied high, total frame latency from start to the frame_done cycle is ERASE_CYCLES + exp_time + 2^N + 1 + 3·NUM_PIXELS + 1.
- bus_oe and any read bit are never high in the same cycle.

## Configuration
- PIXEL_GRAY_EN defined:
  - bus_o carries the Gray code of the convert counter.
  - The captured bus_i is converted Gray→binary before loading pix_data.
- PIXEL_GRAY_EN undefined: binary counter on bus_o, and bus_i is captured raw.
- Timing is identical in both builds.

## Structure
- Package pixel_readout_pkg:
  - state enum
  - default widths (N, NUM_PIXELS)
  - bin2gray/gray2bin functions
- One sub-module, pixel_ramp_counter:
  - N-bit counter with clear/enable and terminal-count flag
  - Gray output under PIXEL_GRAY_EN

## Test plan
- Nominal frame. N=8, NUM_PIXELS=4, ERASE_CYCLES=5, exp_time=10, pix_ready=1. Array model latches 0x12, 0x34, 0x56, 0x78.
  - Pixel codes appear in order with pix_idx 0..3.
  - frame_done pulses at cycle 285; busy falls at cycle 286.
- Backpressure: pix_ready held low 7 cycles while pixel 1 is valid.
  - pix_data=0x34 and pix_idx=1 stay stable.
  - read stays 0; read[2] rises the cycle after the transfer.
- exp_time=0 → expose high exactly 1 cycle; convert starts the next cycle.
- rst asserted during CONVERT at bus_o=0x40.
  - Next cycle all outputs are 0 and bus_oe=0.
  - A following start runs a full correct frame.
- start pulsed during EXPOSE and again in the DONE cycle → both ignored; exactly one frame_done.
- PIXEL_GRAY_EN build:
  - Convert cycle index 3 drives bus_o=0x02.
  - A pixel latching 0x0C outputs pix_data=0x08.
